timer_sched: RTL and testbench

- Multi-channel periodic/one-shot tick scheduler built around one shared prescaler.
- Replaces hard-coded timer instances: firmware-style register writes configure the rate, period and mode of each channel.
- Outputs one-cycle registered tick pulses to the datapath (e.g. FIFO writers/readers), plus sticky pending flags with acknowledge and a combined interrupt.

---
 rtl/timer_sched_pkg.sv | 18 +
 rtl/timer_sched_chan.sv | 91 +++++++++
 rtl/timer_sched.sv | 89 ++++++++
 tb/tb_timer_sched.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_sched_pkg.sv
// Shared constants and types for the multi-channel tick scheduler.
package timer_sched_pkg;

    // Register map: 0 = prescaler divisor, then period/ctrl pairs per channel.
    localparam logic [3:0] ADDR_PRESC   = 4'd0;
    localparam logic [3:0] ADDR_CH_BASE = 4'd2;

    // Ctrl register bit positions.
    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_ONESHOT = 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } ch_state_e;

endpackage

// File: rtl/timer_sched_chan.sv
// One scheduler channel: IDLE/RUN/DONE FSM, base-tick counter, tick pulse and
// sticky pending flag.
module timer_sched_chan
    import timer_sched_pkg::*;
#(
    parameter int unsigned PERIOD_W = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                base_tick_i,
    input  logic                per_wr_i,
    input  logic                ctrl_wr_i,
    input  logic [PERIOD_W-1:0] per_data_i,
    input  logic                ctrl_en_i,
    input  logic                ctrl_oneshot_i,
    input  logic                ack_i,
    output logic                tick_o,
    output logic                pend_o,
    output logic                busy_o
);

    ch_state_e           state_q, state_d;
    logic [PERIOD_W-1:0] ccnt_q, ccnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                oneshot_q, oneshot_d;
    logic                tick_q;
    logic                pend_q, pend_d;
    logic                fire;

    // Next state: a ctrl write overrides any fire decision in the same cycle.
    always_comb begin
        state_d   = state_q;
        ccnt_d    = ccnt_q;
        period_d  = period_q;
        oneshot_d = oneshot_q;
        fire      = 1'b0;

        if (ctrl_wr_i) begin
            if (ctrl_en_i) begin
                state_d   = StRun;
                ccnt_d    = '0;
                oneshot_d = ctrl_oneshot_i;
            end else begin
                state_d = StIdle;
            end
        end else if (state_q == StRun && base_tick_i) begin
            // >= so a period lowered below ccnt fires rather than wrapping.
            if (ccnt_q >= period_q) begin
                fire   = 1'b1;
                ccnt_d = '0;
                if (oneshot_q) begin
                    state_d = StDone;
                end
            end else begin
                ccnt_d = ccnt_q + 1'b1;
            end
        end

        // Compare above uses the old period; a new one applies next compare.
        if (per_wr_i) begin
            period_d = per_data_i;
        end

        // A new fire beats a simultaneous acknowledge.
        pend_d = fire | (pend_q & ~ack_i);
    end

    // Channel state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            ccnt_q    <= '0;
            period_q  <= '0;
            oneshot_q <= 1'b0;
            tick_q    <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ccnt_q    <= ccnt_d;
            period_q  <= period_d;
            oneshot_q <= oneshot_d;
            tick_q    <= fire;
            pend_q    <= pend_d;
        end
    end

    assign tick_o = tick_q;
    assign pend_o = pend_q;
    assign busy_o = (state_q == StRun);

endmodule

// File: rtl/timer_sched.sv
// Multi-channel periodic/one-shot tick scheduler sharing one prescaler.
module timer_sched
    import timer_sched_pkg::*;
#(
    parameter int unsigned           NCH       = 4,
    parameter int unsigned           PRESC_W   = 16,
    parameter int unsigned           PERIOD_W  = 16,
    parameter logic [PRESC_W-1:0]    DEF_PRESC = 16'd59999,
    localparam int unsigned          DataW     = (PRESC_W > PERIOD_W) ? PRESC_W : PERIOD_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_i,
    input  logic [3:0]       addr_i,
    input  logic [DataW-1:0] data_i,
    input  logic [NCH-1:0]   ack_i,
    output logic [NCH-1:0]   tick_o,
    output logic [NCH-1:0]   pend_o,
    output logic [NCH-1:0]   busy_o,
    output logic             irq_o
);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] pcnt_q, pcnt_d;
    logic               base_tick_q, base_tick_d;
    logic               irq_q;
    logic               presc_wr;
    logic [3:0]         ch_off;

    assign presc_wr = wr_i && (addr_i == ADDR_PRESC);
    // Channel index lives in ch_off[3:1], period/ctrl select in ch_off[0].
    assign ch_off   = addr_i - ADDR_CH_BASE;

    // Prescaler next state: a divisor write restarts the count with no tick.
    always_comb begin
        presc_d     = presc_q;
        pcnt_d      = pcnt_q;
        base_tick_d = 1'b0;
        if (presc_wr) begin
            presc_d = data_i[PRESC_W-1:0];
            pcnt_d  = '0;
        end else if (pcnt_q == presc_q) begin
            pcnt_d      = '0;
            base_tick_d = 1'b1;
        end else begin
            pcnt_d = pcnt_q + 1'b1;
        end
    end

    // Prescaler and interrupt registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q     <= DEF_PRESC;
            pcnt_q      <= '0;
            base_tick_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            pcnt_q      <= pcnt_d;
            base_tick_q <= base_tick_d;
            irq_q       <= |pend_o;
        end
    end

    assign irq_o = irq_q;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        logic sel;
        assign sel = wr_i && (addr_i >= ADDR_CH_BASE) && (ch_off[3:1] == 3'(g));

        timer_sched_chan #(
            .PERIOD_W (PERIOD_W)
        ) u_chan (
            .clk_i          (clk_i),
            .rst_i          (rst_i),
            .base_tick_i    (base_tick_q),
            .per_wr_i       (sel && !ch_off[0]),
            .ctrl_wr_i      (sel && ch_off[0]),
            .per_data_i     (data_i[PERIOD_W-1:0]),
            .ctrl_en_i      (data_i[CTRL_EN]),
            .ctrl_oneshot_i (data_i[CTRL_ONESHOT]),
            .ack_i          (ack_i[g]),
            .tick_o         (tick_o[g]),
            .pend_o         (pend_o[g]),
            .busy_o         (busy_o[g])
        );
    end

endmodule

// File: tb/tb_timer_sched.sv
// Self-checking bench for timer_sched: directed scenarios plus a randomized
// run compared against a behavioural model of the scheduler rules.
module tb_timer_sched;

    localparam int NCH = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            wr = 1'b0;
    logic [3:0]      addr = '0;
    logic [15:0]     data = '0;
    logic [NCH-1:0]  ack = '0;
    logic [NCH-1:0]  tick_o, pend_o, busy_o;
    logic            irq_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Behavioural model state (0 idle, 1 run, 2 done).
    int m_presc, m_pcnt, m_bt;
    int m_per[NCH], m_cnt[NCH], m_st[NCH], m_os[NCH], m_tick[NCH], m_pend[NCH];
    int m_irq;

    timer_sched #(
        .NCH       (NCH),
        .PRESC_W   (16),
        .PERIOD_W  (16),
        .DEF_PRESC (16'd59999)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .wr_i   (wr),
        .addr_i (addr),
        .data_i (data),
        .ack_i  (ack),
        .tick_o (tick_o),
        .pend_o (pend_o),
        .busy_o (busy_o),
        .irq_o  (irq_o)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_presc = 59999; m_pcnt = 0; m_bt = 0; m_irq = 0;
        for (int c = 0; c < NCH; c++) begin
            m_per[c] = 0; m_cnt[c] = 0; m_st[c] = 0; m_os[c] = 0;
            m_tick[c] = 0; m_pend[c] = 0;
        end
    endtask

    // One clock of the scheduler rules, applied with the inputs of this cycle.
    task automatic model_step();
        int any_pend = 0;
        int a = int'(addr);
        for (int c = 0; c < NCH; c++) if (m_pend[c] != 0) any_pend = 1;
        for (int c = 0; c < NCH; c++) begin
            bit hit  = wr && a >= 2 && ((a - 2) / 2) == c;
            bit fire = 0;
            if (hit && a % 2 == 1) begin
                if (data[0]) begin
                    m_st[c] = 1; m_cnt[c] = 0; m_os[c] = data[1];
                end else begin
                    m_st[c] = 0;
                end
            end else if (m_st[c] == 1 && m_bt == 1) begin
                if (m_cnt[c] >= m_per[c]) begin
                    fire = 1; m_cnt[c] = 0;
                    if (m_os[c] != 0) m_st[c] = 2;
                end else begin
                    m_cnt[c]++;
                end
            end
            if (hit && a % 2 == 0) m_per[c] = int'(data);
            m_tick[c] = fire;
            m_pend[c] = (fire || (m_pend[c] != 0 && !ack[c])) ? 1 : 0;
        end
        m_irq = any_pend;
        if (wr && a == 0) begin
            m_presc = int'(data); m_pcnt = 0; m_bt = 0;
        end else if (m_pcnt == m_presc) begin
            m_pcnt = 0; m_bt = 1;
        end else begin
            m_pcnt++; m_bt = 0;
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cycle();
        if (rst) model_reset();
        else model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [15:0] d);
        wr = 1'b1; addr = a; data = d;
        cycle();
        wr = 1'b0; addr = '0; data = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bit seen = 0;
        do_reset();
        wr_reg(4'd0, 16'd0);
        wr_reg(4'd2, 16'd1);
        wr_reg(4'd3, 16'd1);
        repeat (10) cycle();
        // Mid-cycle assertion: outputs must clear without a clock edge.
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (tick_o !== '0) begin errors++; $display("FAIL reset_tick got %b want 0", tick_o); end
        checks++;
        if (pend_o !== '0) begin errors++; $display("FAIL reset_pend got %b want 0", pend_o); end
        checks++;
        if (busy_o !== '0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
        checks++;
        if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq_o); end
        @(posedge clk);
        #1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            cycle();
            if (tick_o !== '0) seen = 1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL reset_quiet got tick_seen=1 want 0"); end
    endtask

    task automatic test_periodic();
        int t[$];
        bit wide = 0;
        logic prev = 1'b0;
        do_reset();
        wr_reg(4'd0, 16'd3);
        wr_reg(4'd2, 16'd2);
        wr_reg(4'd3, 16'd1);
        checks++;
        if (busy_o[0] !== 1'b1) begin errors++; $display("FAIL periodic_busy got %b want 1", busy_o[0]); end
        for (int i = 0; i < 70; i++) begin
            cycle();
            if (tick_o[0] === 1'b1) t.push_back(cyc);
            if (tick_o[0] === 1'b1 && prev === 1'b1) wide = 1;
            prev = tick_o[0];
        end
        checks++;
        if (t.size() < 4) begin errors++; $display("FAIL periodic_count got %0d want >=4", t.size()); end
        for (int i = 1; i < t.size(); i++) begin
            checks++;
            if (t[i] - t[i-1] != 12) begin
                errors++;
                $display("FAIL periodic_interval got %0d want 12", t[i] - t[i-1]);
            end
        end
        checks++;
        if (wide) begin errors++; $display("FAIL periodic_width got >1 cycle want 1"); end
    endtask

    task automatic test_oneshot();
        int n = 0;
        int extra = 0;
        bit got = 0;
        do_reset();
        wr_reg(4'd0, 16'd0);
        wr_reg(4'd4, 16'd4);
        wr_reg(4'd5, 16'd3);
        n = 1;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle();
            n++;
            if (tick_o[1] === 1'b1) got = 1;
        end
        checks++;
        if (!got || n < 6 || n > 7) begin
            errors++;
            $display("FAIL oneshot_latency got %0d (seen=%0d) want 6..7", n, got);
        end
        cycle();
        checks++;
        if (busy_o[1] !== 1'b0) begin errors++; $display("FAIL oneshot_busy got %b want 0", busy_o[1]); end
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (tick_o[1] === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL oneshot_extra got %0d want 0", extra); end
    endtask

    task automatic test_pend_ack();
        do_reset();
        wr_reg(4'd0, 16'd0);
        wr_reg(4'd2, 16'd3);
        wr_reg(4'd3, 16'd3);
        repeat (3) cycle();
        // Now in the fire cycle: ack collides with the set.
        ack[0] = 1'b1;
        cycle();
        checks++;
        if (tick_o[0] !== 1'b1) begin errors++; $display("FAIL ack_tick got %b want 1", tick_o[0]); end
        checks++;
        if (pend_o[0] !== 1'b1) begin errors++; $display("FAIL ack_collide got %b want 1", pend_o[0]); end
        cycle();
        ack[0] = 1'b0;
        checks++;
        if (pend_o[0] !== 1'b0) begin errors++; $display("FAIL ack_clear got %b want 0", pend_o[0]); end
        checks++;
        if (irq_o !== 1'b1) begin errors++; $display("FAIL ack_irq_lag got %b want 1", irq_o); end
        cycle();
        checks++;
        if (irq_o !== 1'b0) begin errors++; $display("FAIL ack_irq_clear got %b want 0", irq_o); end
    endtask

    task automatic test_disable_race();
        do_reset();
        wr_reg(4'd0, 16'd0);
        wr_reg(4'd2, 16'd2);
        wr_reg(4'd3, 16'd1);
        repeat (2) cycle();
        // Base tick is high and ccnt == period in this cycle.
        wr_reg(4'd3, 16'd0);
        checks++;
        if (tick_o[0] !== 1'b0) begin errors++; $display("FAIL race_tick got %b want 0", tick_o[0]); end
        checks++;
        if (busy_o[0] !== 1'b0) begin errors++; $display("FAIL race_busy got %b want 0", busy_o[0]); end
        checks++;
        if (pend_o[0] !== 1'b0) begin errors++; $display("FAIL race_pend got %b want 0", pend_o[0]); end
    endtask

    task automatic test_shrink_badaddr();
        int gap = 0;
        bit got = 0;
        do_reset();
        wr_reg(4'd0, 16'd0);
        wr_reg(4'd6, 16'd100);
        wr_reg(4'd7, 16'd1);
        repeat (50) cycle();
        wr_reg(4'd6, 16'd10);
        checks++;
        if (tick_o[2] !== 1'b0) begin errors++; $display("FAIL shrink_early got %b want 0", tick_o[2]); end
        cycle();
        checks++;
        if (tick_o[2] !== 1'b1) begin errors++; $display("FAIL shrink_fire got %b want 1", tick_o[2]); end
        wr_reg(4'd15, 16'hffff);
        wr_reg(4'd1, 16'hffff);
        gap = 2;
        for (int i = 0; i < 30 && !got; i++) begin
            cycle();
            gap++;
            if (tick_o[2] === 1'b1) got = 1;
        end
        checks++;
        if (!got || gap != 11) begin
            errors++;
            $display("FAIL badaddr_interval got %0d (seen=%0d) want 11", gap, got);
        end
        checks++;
        if (busy_o !== 4'b0100) begin errors++; $display("FAIL badaddr_busy got %b want 0100", busy_o); end
    endtask

    task automatic test_random();
        logic [NCH-1:0] et, ep, eb;
        int shown = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            wr = ($urandom_range(0, 5) == 0);
            addr = 4'($urandom_range(0, 15));
            if (addr == 4'd0) data = 16'($urandom_range(0, 3));
            else data = 16'($urandom_range(0, 9));
            ack = NCH'($urandom);
            cycle();
            for (int c = 0; c < NCH; c++) begin
                et[c] = (m_tick[c] != 0);
                ep[c] = (m_pend[c] != 0);
                eb[c] = (m_st[c] == 1);
            end
            checks++;
            if (tick_o !== et || pend_o !== ep || busy_o !== eb || irq_o !== (m_irq != 0)) begin
                errors++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random_cyc%0d got t=%b p=%b b=%b i=%b want t=%b p=%b b=%b i=%0d",
                             cyc, tick_o, pend_o, busy_o, irq_o, et, ep, eb, m_irq);
                end
            end
        end
        wr = 1'b0; addr = '0; data = '0; ack = '0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_periodic();
        test_oneshot();
        test_pend_ack();
        test_disable_race();
        test_shrink_badaddr();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
